// File: rtl/dac_spi_out.sv
// DAC output stage: biases and scales a filter sample to a DAC code, then sends
// {CFG, code} as one SPI frame followed by an LDAC pulse. Optional macro DAC_SAT_EN enables code saturation.
module dac_spi_out #(
  parameter int          DAC_W   = 12,
  parameter int          SHIFT   = 11,
  parameter logic [31:0] OFFSET  = 32'h003FFFFF,
  parameter logic [3:0]  CFG     = 4'b0011,
  parameter int          CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_in,
  input  logic        valid_in,
  output logic        sclk,
  output logic        mosi,
  output logic        cs_n,
  output logic        ldac_n,
  output logic        busy,
  output logic        overrun
);

  localparam int F  = 4 + DAC_W;
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(F);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(F - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_END, S_LATCH} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [BW-1:0]    bit_cnt;
  logic             low_ph;
  logic [F-1:0]     shreg;
  logic [DAC_W-1:0] hold;
  logic             pend;
  logic             take;

  // 33-bit sum so the bias can never overflow the signed sample
  logic signed [32:0] biased;
  assign biased = $signed({data_in[31], data_in}) + $signed({OFFSET[31], OFFSET});

  logic [DAC_W-1:0] code;
`ifdef DAC_SAT_EN
  always_comb begin
    code = biased[SHIFT+DAC_W-1:SHIFT];
    if (biased[32])                     code = '0;
    else if (|biased[31:SHIFT+DAC_W])   code = '1;
  end
`else
  assign code = biased[SHIFT+DAC_W-1:SHIFT];
`endif

  assign take = (state == S_IDLE) && pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      low_ph  <= 1'b0;
      shreg   <= '0;
      hold    <= '0;
      pend    <= 1'b0;
      overrun <= 1'b0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      cs_n    <= 1'b1;
      ldac_n  <= 1'b1;
      busy    <= 1'b0;
    end else begin
      // A strobe coinciding with the IDLE hand-off refills the slot without loss
      if (valid_in) begin
        hold <= code;
        pend <= 1'b1;
        if (pend && !take) overrun <= 1'b1;
      end else if (take) begin
        pend <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (pend) begin
            shreg <= {CFG, hold};
            mosi  <= CFG[3];
            cs_n  <= 1'b0;
            busy  <= 1'b1;
            cnt   <= '0;
            state <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            sclk    <= 1'b1;
            low_ph  <= 1'b0;
            bit_cnt <= '0;
            state   <= S_SHIFT;
          end else cnt <= cnt + 1'b1;
        end
        S_SHIFT: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (!low_ph) begin
              sclk   <= 1'b0;
              low_ph <= 1'b1;
              mosi   <= shreg[F-2];
              shreg  <= {shreg[F-2:0], 1'b0};
            end else if (bit_cnt == BIT_LAST) begin
              cs_n  <= 1'b1;
              mosi  <= 1'b0;
              state <= S_END;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              sclk    <= 1'b1;
              low_ph  <= 1'b0;
            end
          end else cnt <= cnt + 1'b1;
        end
        S_END: begin
          if (cnt == CNT_LAST) begin
            cnt    <= '0;
            ldac_n <= 1'b0;
            state  <= S_LATCH;
          end else cnt <= cnt + 1'b1;
        end
        S_LATCH: begin
          if (cnt == CNT_LAST) begin
            cnt    <= '0;
            ldac_n <= 1'b1;
            busy   <= 1'b0;
            state  <= S_IDLE;
          end else cnt <= cnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_spi_out.sv
// Directed bench for dac_spi_out: decodes SPI frames from the pins and checks
// codes, frame timing, overrun handling and mid-frame reset.
module tb_dac_spi_out;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data_in = '0;
  logic        valid_in = 1'b0;
  logic        sclk, mosi, cs_n, ldac_n, busy, overrun;

  int checks = 0;
  int errors = 0;

  dac_spi_out dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
    .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .ldac_n(ldac_n),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic strobe(input logic [31:0] d);
    @(negedge clk);
    data_in  = d;
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  // Waits for cs_n low, shifts in mosi on each sclk rise, stops when ldac_n rises.
  task automatic capture(output logic [15:0] frm, output int dur, output int ldl, output bit to);
    int   w;
    logic ps, pl;
    frm = '0; dur = 0; ldl = 0; to = 1'b0; w = 0;
    @(negedge clk);
    while (cs_n !== 1'b0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    if (cs_n !== 1'b0) begin
      to = 1'b1;
      return;
    end
    ps = sclk; pl = ldac_n;
    to = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      dur++;
      if (sclk === 1'b1 && ps === 1'b0) frm = {frm[14:0], mosi};
      if (ldac_n === 1'b0) ldl++;
      if (ldac_n === 1'b1 && pl === 1'b0) begin
        to = 1'b0;
        break;
      end
      ps = sclk; pl = ldac_n;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({sclk, mosi, cs_n, ldac_n, busy, overrun} !== 6'b001100) begin
      errors++;
      $display("FAIL reset_outputs: got %b, want 001100", {sclk, mosi, cs_n, ldac_n, busy, overrun});
    end
    rst = 1'b0;
  endtask

  task automatic test_frame(input string nm, input logic [31:0] d, input logic [15:0] exp);
    logic [15:0] f; int dur, ldl; bit to;
    strobe(d);
    capture(f, dur, ldl, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL %s_timeout: got no complete frame, want frame %h", nm, exp);
    end
    checks++;
    if (f !== exp) begin
      errors++;
      $display("FAIL %s_frame: got %h, want %h", nm, f, exp);
    end
    checks++;
    if (dur !== 140) begin
      errors++;
      $display("FAIL %s_duration: got %0d, want 140", nm, dur);
    end
    checks++;
    if (ldl !== 4) begin
      errors++;
      $display("FAIL %s_ldac_width: got %0d, want 4", nm, ldl);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_after: busy got %b, want 0", nm, busy);
    end
  endtask

  task automatic test_saturation;
`ifdef DAC_SAT_EN
    test_frame("sat_hi", 32'h00500000, 16'h3FFF);
    test_frame("sat_lo", 32'hFFB00000, 16'h3000);
`else
    test_frame("wrap", 32'h00500000, 16'h31FF);
`endif
  endtask

  task automatic test_latency;
    int w;
    strobe(32'h0);
    checks++;
    if (cs_n !== 1'b1) begin
      errors++;
      $display("FAIL latency_plus1: cs_n got %b, want 1", cs_n);
    end
    @(negedge clk);
    checks++;
    if (cs_n !== 1'b0 || busy !== 1'b1 || mosi !== 1'b0 || sclk !== 1'b0) begin
      errors++;
      $display("FAIL latency_plus2: cs_n/busy/mosi/sclk got %b%b%b%b, want 0100", cs_n, busy, mosi, sclk);
    end
    w = 0;
    while (busy !== 1'b0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL latency_drain: busy got %b, want 0", busy);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] f; int dur, ldl; bit to;
    strobe(32'h00400000);
    repeat (10) @(negedge clk);
    data_in = 32'h00100000; valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    capture(f, dur, ldl, to);
    checks++;
    if (to || f !== 16'h3FFF) begin
      errors++;
      $display("FAIL b2b_first: got %h (timeout %0d), want 3fff", f, to);
    end
    @(negedge clk);
    checks++;
    if (cs_n !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap: cs_n got %b one cycle after ldac_n rise, want 0", cs_n);
    end
    capture(f, dur, ldl, to);
    checks++;
    if (to || f !== 16'h39FF || dur !== 139) begin
      errors++;
      $display("FAIL b2b_second: got %h dur %0d, want 39ff dur 139", f, dur);
    end
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL b2b_no_overrun: got %b, want 0", overrun);
    end
  endtask

  task automatic test_overrun;
    logic [15:0] f; int dur, ldl; bit to;
    strobe(32'h0);
    repeat (20) @(negedge clk);
    strobe(32'h00400000);
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_after_b: got %b, want 0", overrun);
    end
    repeat (20) @(negedge clk);
    strobe(32'h00100000);
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_after_c: got %b, want 1", overrun);
    end
    capture(f, dur, ldl, to);
    capture(f, dur, ldl, to);
    checks++;
    if (to || f !== 16'h39FF) begin
      errors++;
      $display("FAIL ovr_second_frame: got %h (timeout %0d), want 39ff", f, to);
    end
    @(negedge clk);
    checks++;
    if (overrun !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ovr_sticky: overrun/busy got %b%b, want 10", overrun, busy);
    end
  endtask

  task automatic test_reset_mid_shift;
    int   rises, w;
    logic ps;
    strobe(32'h00400000);
    rises = 0; w = 0; ps = sclk;
    while (rises < 7 && w < 200) begin
      @(negedge clk);
      w++;
      if (sclk === 1'b1 && ps === 1'b0) rises++;
      ps = sclk;
    end
    checks++;
    if (rises != 7 || cs_n !== 1'b0) begin
      errors++;
      $display("FAIL midrst_reach_bit7: rises %0d cs_n %b, want 7 and 0", rises, cs_n);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({cs_n, sclk, busy, ldac_n, mosi, overrun} !== 6'b100100) begin
      errors++;
      $display("FAIL midrst_outputs: cs_n/sclk/busy/ldac_n/mosi/overrun got %b, want 100100",
               {cs_n, sclk, busy, ldac_n, mosi, overrun});
    end
    repeat (3) @(negedge clk);
    checks++;
    if (cs_n !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_no_restart: cs_n/busy got %b%b, want 10", cs_n, busy);
    end
    rst = 1'b0;
    test_frame("post_rst", 32'h0, 16'h37FF);
  endtask

  initial begin
    test_reset();
    test_frame("midscale", 32'h0, 16'h37FF);
    test_frame("fullscale", 32'h00400000, 16'h3FFF);
    test_saturation();
    test_latency();
    test_back_to_back();
    test_overrun();
    test_reset_mid_shift();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
